// File: rtl/seg7_scan_decoder_if.sv
// Bus and readback bundle for seg7_scan_decoder: multiplexed active-low seven-segment bus
// in, recovered BCD digits and capture status out.
interface seg7_scan_decoder_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [NUM_DIGITS-1:0]   an_n;
  logic [6:0]              seg_n;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic [NUM_DIGITS-1:0]   invalid_pat;
  logic                    update;
  logic [2:0]              upd_idx;

  modport master (
    output an_n, seg_n,
    input  digits, digit_valid, invalid_pat, update, upd_idx
  );

  modport slave (
    input  an_n, seg_n,
    output digits, digit_valid, invalid_pat, update, upd_idx
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers the BCD digit shown on each position of a multiplexed active-low 7-segment bus.
// Define SEG7_SYNC_EN to add a two-flop synchronizer on an_n/seg_n for asynchronous pins.
module seg7_scan_decoder #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input logic                clk,
  input logic                rst,
  seg7_scan_decoder_if.slave bus
);
  localparam int unsigned CntW = $clog2(SETTLE_CYCLES) + 1;

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  logic [NUM_DIGITS-1:0] an_in;
  logic [6:0]            seg_in;

`ifdef SEG7_SYNC_EN
  logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q;
  logic [6:0]            seg_s1_q, seg_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      an_s1_q  <= '1;
      an_s2_q  <= '1;
      seg_s1_q <= '1;
      seg_s2_q <= '1;
    end else begin
      an_s1_q  <= bus.an_n;
      an_s2_q  <= an_s1_q;
      seg_s1_q <= bus.seg_n;
      seg_s2_q <= seg_s1_q;
    end
  end

  assign an_in  = an_s2_q;
  assign seg_in = seg_s2_q;
`else
  assign an_in  = bus.an_n;
  assign seg_in = bus.seg_n;
`endif

  logic [NUM_DIGITS-1:0]   an_q, an_p_q;
  logic [6:0]              seg_q, seg_p_q;
  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   invalid_q, invalid_d;
  logic                    update_q, update_d;
  logic [2:0]              upd_idx_q, upd_idx_d;

  logic [3:0] zeros;
  logic [2:0] sel_idx;
  logic       legal;
  logic       changed;
  logic       capture;
  logic       dec_hit;
  logic       dec_blank;
  logic [3:0] dec_val;

  // Exactly one low anode selects a position; off or multi-select is ignored.
  always_comb begin
    zeros   = '0;
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) begin
        zeros   = zeros + 4'd1;
        sel_idx = 3'(i);
      end
    end
    legal   = (zeros == 4'd1);
    changed = ({an_q, seg_q} != {an_p_q, seg_p_q});
  end

  always_comb begin
    dec_hit   = 1'b1;
    dec_blank = 1'b0;
    dec_val   = 4'hF;
    case (seg_q)
      7'h01:   dec_val = 4'd0;
      7'h4F:   dec_val = 4'd1;
      7'h12:   dec_val = 4'd2;
      7'h06:   dec_val = 4'd3;
      7'h4C:   dec_val = 4'd4;
      7'h24:   dec_val = 4'd5;
      7'h20:   dec_val = 4'd6;
      7'h0F:   dec_val = 4'd7;
      7'h00:   dec_val = 4'd8;
      7'h04:   dec_val = 4'd9;
      7'h7F: begin
        dec_hit   = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (legal) begin
          state_d = StSettle;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StSettle: begin
        if (!legal) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (changed) begin
          cnt_d = CntW'(1);
        end else if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
          capture = 1'b1;
          state_d = StHold;
          cnt_d   = CntW'(SETTLE_CYCLES);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (!legal) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (changed) begin
          state_d = StSettle;
          cnt_d   = CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // An undecodable pattern keeps the last good digit and only raises invalid_pat.
  always_comb begin
    digits_d  = digits_q;
    valid_d   = valid_q;
    invalid_d = invalid_q;
    update_d  = 1'b0;
    upd_idx_d = upd_idx_q;
    if (capture) begin
      update_d  = 1'b1;
      upd_idx_d = sel_idx;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (3'(i) == sel_idx) begin
          if (dec_hit) begin
            digits_d[4*i +: 4] = dec_val;
            valid_d[i]         = 1'b1;
            invalid_d[i]       = 1'b0;
          end else if (dec_blank) begin
            digits_d[4*i +: 4] = 4'hF;
            valid_d[i]         = 1'b0;
            invalid_d[i]       = 1'b0;
          end else begin
            invalid_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q      <= '1;
      seg_q     <= 7'h7F;
      an_p_q    <= '1;
      seg_p_q   <= 7'h7F;
      state_q   <= StIdle;
      cnt_q     <= '0;
      digits_q  <= '1;
      valid_q   <= '0;
      invalid_q <= '0;
      update_q  <= 1'b0;
      upd_idx_q <= '0;
    end else begin
      an_q      <= an_in;
      seg_q     <= seg_in;
      an_p_q    <= an_q;
      seg_p_q   <= seg_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      invalid_q <= invalid_d;
      update_q  <= update_d;
      upd_idx_q <= upd_idx_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.invalid_pat = invalid_q;
  assign bus.update      = update_q;
  assign bus.upd_idx     = upd_idx_q;
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side companion to the GoldMiner seven-segment encoder.
- Watches a multiplexed, active-low seven-segment bus (anode enables plus segment lines) and recovers the BCD digit shown on each position.
- Used for on-chip score/timer readback and as a self-check monitor on the display path.
- Segment data is captured only after the bus has been stable for a programmable number of cycles.

Parameters:
- NUM_DIGITS, 4: number of multiplexed display positions (1..8).
- SETTLE_CYCLES, 16: consecutive identical samples required before capture (>=2). Counter width is clog2(SETTLE_CYCLES)+1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- an_n  in  NUM_DIGITS  anode enables, active-low; bit i selects position i
- seg_n  in  7  segments, active-low; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g
- digits  out  4*NUM_DIGITS  decoded value; position i at bits [4i+3:4i]
- digit_valid  out  NUM_DIGITS  position i holds a decoded 0-9 value
- invalid_pat  out  NUM_DIGITS  last capture on position i was an undecodable pattern
- update  out  1  one-cycle pulse on every capture
- upd_idx  out  3  position index of the capture flagged by update

Behaviour:
- Reset values:
  - digits = all 4'hF
  - digit_valid = 0
  - invalid_pat = 0
  - update = 0
  - upd_idx = 0
  - FSM = IDLE
  - sample registers: an_q = all 1s, seg_q = 7'h7F
  - cnt = 0
- Input stage: an_n and seg_n are registered every cycle into an_q/seg_q. All decisions use only the registered copies.
- Selection check: an_q is legal when exactly one bit is 0. All-ones (display off) or two or more zeros is illegal.
- FSM states: IDLE, SETTLE, HOLD.
  - IDLE: entered when an_q is illegal; cnt = 0. Goes to SETTLE, with cnt = 1, on the first cycle an_q is legal.
  - SETTLE:
    - If {an_q, seg_q} equals its previous value, cnt increments.
    - If it differs and an_q is still legal, cnt restarts at 1 and the FSM stays in SETTLE.
    - If an_q becomes illegal, go to IDLE.
    - When cnt reaches SETTLE_CYCLES, capture on that edge and go to HOLD.
  - HOLD: no further captures. Any change in {an_q, seg_q} goes to SETTLE (cnt = 1), or to IDLE if an_q is illegal.
- Capture at position i, where i is the index of the zero bit in an_q:
  - Decode table (seg_n -> value):
    - 7'h01 -> 0
    - 7'h4F -> 1
    - 7'h12 -> 2
    - 7'h06 -> 3
    - 7'h4C -> 4
    - 7'h24 -> 5
    - 7'h20 -> 6
    - 7'h0F -> 7
    - 7'h00 -> 8
    - 7'h04 -> 9
  - Match: digits[i] = value, digit_valid[i] = 1, invalid_pat[i] = 0.
  - 7'h7F (blank, which the encoder emits for 10-15): digits[i] = 4'hF, digit_valid[i] = 0, invalid_pat[i] = 0.
  - Any other pattern: digits[i] unchanged, digit_valid[i] unchanged, invalid_pat[i] = 1.
  - In all three cases: update = 1 and upd_idx = i for exactly the one cycle after the capture edge.
- Latency: a bus value applied before edge k and held is captured at edge k+SETTLE_CYCLES. Outputs are visible in the following cycle.
- Recapture rule: an identical value re-presented after a change (e.g. a scan returning to the same digit) is captured again and pulses update again.
- Glitch rule: a change shorter than SETTLE_CYCLES samples never captures. Other positions are never modified.
- Width: upd_idx is zero-extended when NUM_DIGITS < 8.
- Reset mid-operation: rst has priority over every state. All registers take their reset values on that edge and no update is generated.

Optional Feature:
- Macro: SEG7_SYNC_EN.
- Defined: a two-flop synchronizer (reset to all 1s) is inserted on an_n and seg_n ahead of the input stage, for asynchronous external pins. Capture latency becomes SETTLE_CYCLES+2 edges.
- Undefined: single input register only, and inputs must be synchronous to clk. Latency is SETTLE_CYCLES edges.

Test Plan:
- Reset check: hold rst 3 cycles with an_n=4'b1110, seg_n=7'h12 -> digits=16'hFFFF, digit_valid=0, update=0; release and hold -> capture of 2 at position 0 after 16 edges, update pulse with upd_idx=0.
- Full scan: scan positions 3..0 showing 4,0,7,9, dwelling 40 cycles each -> digits=16'h4079, digit_valid=4'hF, four update pulses with upd_idx=3,2,1,0.
- Glitch rejection: during a dwell on position 1, change seg_n to 7'h00 for 10 cycles, then restore -> no capture of 8; capture of the original value happens 16 edges after restore.
- Pattern handling: present 7'h7F on position 2 -> digits[11:8]=F, digit_valid[2]=0; present 7'h55 on position 2 after a prior 5 -> digits[11:8]=5, digit_valid[2]=1, invalid_pat[2]=1.
- Illegal anodes: an_n=4'b1100 or 4'b1111 for 100 cycles -> no update, FSM in IDLE; returning to 4'b1101 with 7'h4F -> digits[7:4]=1.
- Reset mid-settle: assert rst at cnt=10 -> all outputs at reset values and no update pulse; after release, capture takes a full 16 edges. Rerun this scenario with SEG7_SYNC_EN defined and expect 18 edges.
